ans_freq_table: RTL and testbench
=================================

# ans_freq_table

Symbol-statistics stage feeding `ans_encoder`. It holds a per-symbol frequency table and, once loaded, builds cumulative counts by a sequential prefix sum. It then converts a stream of raw symbols into `(s_count, s_cumulative, total_count)` triples over a valid/ready handshake. Its output port connects directly to the encoder's `s_count`/`s_cumulative`/`total_count`/`in_vld`/`in_rdy`.

## Interface
- `NUM_SYMS`, default `1 << `SYM_WIDTH``: table depth; symbol index width is `SYM_WIDTH`.
- `clk  in  1`: single clock; every register updates on its rising edge.
- `rst_n  in  1`: synchronous active-low reset, sampled on the rising edge of `clk`.
- `ena  in  1`: global enable; when low all state holds.
- `cfg_we  in  1`: write strobe for one table entry (LOAD state only).
- `cfg_sym  in  SYM_WIDTH`: entry index to write.
- `cfg_count  in  CNT_WIDTH`: frequency value to write.
- `cfg_done  in  1`: ends LOAD and starts BUILD.
- `cfg_clear  in  1`: returns to LOAD and zeroes all counts.
- `tbl_ready  out  1`: high in RUN only.
- `sym_in  in  SYM_WIDTH`: symbol to look up.
- `sym_vld  in  1`, `sym_rdy  out  1`: input handshake.
- `s_count  out  CNT_WIDTH`: frequency of the accepted symbol.
- `s_cumulative  out  SYM_WIDTH+CNT_WIDTH`: sum of the counts of all lower-indexed symbols.
- `total_count  out  SYM_WIDTH+CNT_WIDTH`: sum of all counts; static in RUN.
- `out_vld  out  1`, `out_rdy  in  1`: output handshake (to encoder `in_vld`/`in_rdy`).
- `err_zero  out  1`: sticky flag for a zero-count lookup (see Configuration).

## Operation
- States: LOAD → BUILD → RUN. `cfg_clear` returns to LOAD from any state.
- Reset (`rst_n`=0 at an edge): state LOAD, all counts and cumulatives 0, build index 0.
  - Outputs after reset: `total_count`=0, `s_count`=0, `s_cumulative`=0, `out_vld`=0, `sym_rdy`=0, `tbl_ready`=0, `err_zero`=0.
- LOAD:
  - `cfg_we` writes `count[cfg_sym] <= cfg_count`; a later write to the same index overwrites.
  - `cfg_done` moves to BUILD with the build index at 0 and the running sum at 0.
  - If `cfg_we` and `cfg_done` are high in the same cycle, the write is included in the build.
- BUILD: each cycle with `ena`=1 processes index i:
  - `cum[i] <= sum`, then `sum <= sum + count[i]`, then `i <= i+1`.
  - After i = NUM_SYMS-1: `total_count <= final sum`, state RUN.
  - `cfg_we` and `cfg_done` are ignored.
- Width rule: the sum is SYM_WIDTH+CNT_WIDTH bits and cannot overflow, since the maximum is NUM_SYMS·(2^CNT_WIDTH−1).
- RUN:
  - `sym_rdy = ena & (!out_vld | out_rdy)`.
  - On `sym_vld & sym_rdy`: `s_count <= count[sym_in]`, `s_cumulative <= cum[sym_in]`, `out_vld <= 1`.
  - Otherwise, `out_vld & out_rdy` clears `out_vld`.
  - Outputs are registered and hold stable while `out_vld & !out_rdy`.
  - `cfg_we` and `cfg_done` are ignored.
- `cfg_clear`: next state LOAD, all counts and cumulatives zeroed, `out_vld`=0, `tbl_ready`=0. `total_count` is zeroed at the same edge. `err_zero` is cleared. `cfg_clear` takes priority over every other input except reset.
- An all-zero table still reaches RUN with `total_count`=0.

## Timing
- Latency: a symbol accepted at edge N gives `out_vld`=1 after edge N. Throughput is one symbol per cycle when `out_rdy`=1.
- The output register is a single stage; a new accept and a drain of the old entry may happen at the same edge.
- With `ena` held high, `tbl_ready` rises exactly NUM_SYMS edges after the edge that sampled `cfg_done`.
- Each `ena`=0 cycle during BUILD adds one cycle to the build.
- `ena`=0 in RUN: `sym_rdy`=0, and `out_vld` and the outputs hold. The edge-`out_vld` clear still requires `ena`=1.
- `rst_n` low mid-BUILD or mid-RUN gives full reset values after that edge; any partial build is discarded.

## Configuration
- `FREQ_ZERO_CHECK_EN` defined:
  - A RUN lookup of a symbol with `count`=0 is accepted (`sym_rdy` handshake completes).
  - No output is produced and `out_vld` is unchanged by that accept.
  - `err_zero` is set and stays set until reset or `cfg_clear`.
  - This protects the encoder from dividing by zero.
- `FREQ_ZERO_CHECK_EN` undefined: zero-count symbols pass through as `s_count`=0 with `out_vld`=1, and `err_zero` is tied to 0.

## Test plan
- Table load and build (SYM_WIDTH=4): write counts sym0=3, sym1=5, sym2=8, all others 0, then `cfg_done` → `tbl_ready` rises exactly 16 edges later with `total_count`=16.
- Lookup: RUN, `out_rdy`=1, stream symbols 1, 0, 2 back-to-back → three consecutive `out_vld` cycles with (5,3), (3,0), (8,8), `total_count`=16 throughout.
- Backpressure: `out_rdy`=0 with `out_vld`=1 and `sym_vld` on sym2 → `sym_rdy`=0 and outputs frozen. Then `out_rdy`=1 → sym2 accepted at the same edge, and the next cycle shows `s_count`=8, `s_cumulative`=8.
- Zero-count lookup of sym7:
  - With `FREQ_ZERO_CHECK_EN`: handshake completes, no `out_vld`, `err_zero`=1 persists.
  - Without it: `out_vld`=1 with `s_count`=0, `s_cumulative`=16.
- Clear mid-BUILD: assert `cfg_clear` at build index 5 → LOAD next cycle, `tbl_ready`=0, `total_count`=0. Reload sym4=10 and build → `total_count`=10, `cum[5]`=10.
- Enable and reset: hold `ena`=0 for 3 cycles during BUILD → `tbl_ready` rises after 19 edges. Pull `rst_n`=0 for one edge in RUN with `out_vld`=1 → all outputs at reset values after that edge.

Source files
------------

// File: rtl/ans_freq_table.sv
// Per-symbol frequency table with sequential prefix-sum build and a registered lookup stage for ans_encoder.
// Optional macro FREQ_ZERO_CHECK_EN: swallow zero-count lookups and raise the sticky err_zero flag.
module ans_freq_table #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 8,
  parameter int NUM_SYMS  = 1 << SYM_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          cfg_we,
  input  logic [SYM_WIDTH-1:0]          cfg_sym,
  input  logic [CNT_WIDTH-1:0]          cfg_count,
  input  logic                          cfg_done,
  input  logic                          cfg_clear,
  output logic                          tbl_ready,
  input  logic [SYM_WIDTH-1:0]          sym_in,
  input  logic                          sym_vld,
  output logic                          sym_rdy,
  output logic [CNT_WIDTH-1:0]          s_count,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] s_cumulative,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] total_count,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          err_zero
);
  localparam int SUM_W = SYM_WIDTH + CNT_WIDTH;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BUILD = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] count [NUM_SYMS];
  logic [SUM_W-1:0]     cum   [NUM_SYMS];
  logic [SYM_WIDTH-1:0] idx;
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     sum_next;
  logic                 build_last;
  logic                 clear;
  logic                 accept;
  logic                 zero_hit;

  assign clear      = ena & cfg_clear;
  assign build_last = (idx == SYM_WIDTH'(NUM_SYMS - 1));
  assign sum_next   = sum + SUM_W'(count[idx]);
  assign tbl_ready  = (state == RUN);
  assign sym_rdy    = tbl_ready & ena & (!out_vld | out_rdy);
  assign accept     = sym_vld & sym_rdy;

`ifdef FREQ_ZERO_CHECK_EN
  assign zero_hit = accept & (count[sym_in] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      err_zero <= 1'b0;
    end else if (zero_hit) begin
      err_zero <= 1'b1;
    end
  end
`else
  assign zero_hit = 1'b0;
  assign err_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ena) begin
      if (cfg_clear) begin
        state_nxt = LOAD;
      end else begin
        case (state)
          LOAD:    if (cfg_done) state_nxt = BUILD;
          BUILD:   if (build_last) state_nxt = RUN;
          RUN:     state_nxt = RUN;
          default: state_nxt = LOAD;
        endcase
      end
    end
  end

  // Table, prefix-sum walker and the single output register stage
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < NUM_SYMS; i++) begin
        count[i] <= '0;
        cum[i]   <= '0;
      end
      idx          <= '0;
      sum          <= '0;
      total_count  <= '0;
      s_count      <= '0;
      s_cumulative <= '0;
      out_vld      <= 1'b0;
    end else if (ena) begin
      case (state)
        LOAD: begin
          if (cfg_we) count[cfg_sym] <= cfg_count;
          if (cfg_done) begin
            idx <= '0;
            sum <= '0;
          end
        end
        BUILD: begin
          cum[idx] <= sum;
          sum      <= sum_next;
          idx      <= idx + 1'b1;
          if (build_last) total_count <= sum_next;
        end
        RUN: begin
          // A swallowed zero-count accept leaves room for the drain of the held entry
          if (accept && !zero_hit) begin
            s_count      <= count[sym_in];
            s_cumulative <= cum[sym_in];
            out_vld      <= 1'b1;
          end else if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ans_freq_table.sv
// Randomized and directed bench for ans_freq_table against a table/prefix-sum/queue reference model.
module tb_ans_freq_table;
  localparam int SW = 4;
  localparam int CW = 8;
  localparam int NS = 16;
  localparam int TW = SW + CW;

  logic          clk = 1'b0;
  logic          rst_n, ena, cfg_we, cfg_done, cfg_clear, sym_vld, out_rdy;
  logic [SW-1:0] cfg_sym, sym_in;
  logic [CW-1:0] cfg_count;
  logic          tbl_ready, sym_rdy, out_vld, err_zero;
  logic [CW-1:0] s_count;
  logic [TW-1:0] s_cumulative, total_count;

  ans_freq_table #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .NUM_SYMS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_sym(cfg_sym),
    .cfg_count(cfg_count), .cfg_done(cfg_done), .cfg_clear(cfg_clear),
    .tbl_ready(tbl_ready), .sym_in(sym_in), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .s_count(s_count), .s_cumulative(s_cumulative), .total_count(total_count),
    .out_vld(out_vld), .out_rdy(out_rdy), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int m;
  } ent_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   mcount [NS];
  int   mode = 0;       // 0 load, 1 build, 2 run
  int   build_left = 0;
  bit   m_err = 1'b0;
  ent_t q [$];

  function automatic int mcum(input int s);
    int acc = 0;
    for (int i = 0; i < s; i++) acc += mcount[i];
    return acc;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, advance the model, compare after the edge
  task automatic cycle();
    bit en, rn, clr, we, dn, hin, hout;
    int ws, wc, s;
    #1;
    en = ena; rn = rst_n; clr = cfg_clear; we = cfg_we; dn = cfg_done;
    ws = int'(cfg_sym); wc = int'(cfg_count); s = int'(sym_in);
    hin  = sym_vld && sym_rdy;
    hout = out_vld && out_rdy && ena;
    if (rn) check("sym_rdy", sym_rdy, (mode == 2) && en && (q.size() == 0 || out_rdy));
    @(posedge clk);
    #1;
    if (!rn || (en && clr)) begin
      mode = 0;
      foreach (mcount[i]) mcount[i] = 0;
      q.delete();
      m_err = 1'b0;
    end else if (en) begin
      case (mode)
        0: begin
          if (we) mcount[ws] = wc;
          if (dn) begin mode = 1; build_left = NS; end
        end
        1: begin
          build_left--;
          if (build_left == 0) mode = 2;
        end
        default: begin
          if (hout) void'(q.pop_front());
          if (hin) begin
`ifdef FREQ_ZERO_CHECK_EN
            if (mcount[s] == 0) m_err = 1'b1;
            else q.push_back('{mcount[s], mcum(s)});
`else
            q.push_back('{mcount[s], mcum(s)});
`endif
          end
        end
      endcase
    end
    check("tbl_ready", tbl_ready, mode == 2);
    check("out_vld", out_vld, q.size() > 0);
    if (q.size() > 0) begin
      check("s_count", s_count, q[0].c);
      check("s_cumulative", s_cumulative, q[0].m);
    end
    check("total_count", total_count, (mode == 2) ? mcum(NS) : 0);
    check("err_zero", err_zero, m_err);
  endtask

  task automatic idle();
    rst_n = 1'b1; ena = 1'b1; cfg_we = 1'b0; cfg_done = 1'b0; cfg_clear = 1'b0;
    sym_vld = 1'b0; out_rdy = 1'b1;
  endtask

  task automatic wr(input int sym, input int cnt, input bit done);
    cfg_we = 1'b1; cfg_sym = SW'(sym); cfg_count = CW'(cnt); cfg_done = done;
    cycle();
    cfg_we = 1'b0; cfg_done = 1'b0;
  endtask

  task automatic clear_tbl();
    cfg_clear = 1'b1;
    cycle();
    cfg_clear = 1'b0;
  endtask

  task automatic wait_ready(inout int n);
    while (!tbl_ready && n < 64) begin
      cycle();
      n++;
    end
  endtask

  task automatic lookup(input int sym, input bit rdy);
    sym_vld = 1'b1; sym_in = SW'(sym); out_rdy = rdy;
    cycle();
    sym_vld = 1'b0;
  endtask

  initial begin
    int n;
    foreach (mcount[i]) mcount[i] = 0;
    idle();
    cfg_sym = '0; cfg_count = '0; sym_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_total", total_count, 0);
    check("rst_s_count", s_count, 0);
    check("rst_s_cum", s_cumulative, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_sym_rdy", sym_rdy, 0);
    check("rst_tbl_ready", tbl_ready, 0);
    check("rst_err_zero", err_zero, 0);
    rst_n = 1'b1;

    // Load 3/5/8, with the last write sharing the cfg_done cycle
    wr(0, 3, 0);
    wr(1, 5, 0);
    wr(2, 8, 1);
    n = 0;
    wait_ready(n);
    check("build_edges", n, 16);
    check("build_total", total_count, 16);

    lookup(1, 1); check("lk1_count", s_count, 5); check("lk1_cum", s_cumulative, 3);
    lookup(0, 1); check("lk0_count", s_count, 3); check("lk0_cum", s_cumulative, 0);
    lookup(2, 1); check("lk2_count", s_count, 8); check("lk2_cum", s_cumulative, 8);
    lookup(1, 1);

    // Backpressure: held entry (5,3) must freeze while sym2 waits
    sym_vld = 1'b1; sym_in = SW'(2); out_rdy = 1'b0;
    #1 check("bp_sym_rdy", sym_rdy, 0);
    cycle();
    check("bp_hold_count", s_count, 5);
    check("bp_hold_cum", s_cumulative, 3);
    lookup(2, 1);
    check("bp_rel_count", s_count, 8);
    check("bp_rel_cum", s_cumulative, 8);
    cycle();

    sym_vld = 1'b1; sym_in = SW'(7); out_rdy = 1'b1;
    #1 check("zero_sym_rdy", sym_rdy, 1);
    cycle();
    sym_vld = 1'b0;
`ifdef FREQ_ZERO_CHECK_EN
    check("zero_no_out", out_vld, 0);
    check("zero_err", err_zero, 1);
    repeat (3) cycle();
    check("zero_err_sticky", err_zero, 1);
`else
    check("zero_out_vld", out_vld, 1);
    check("zero_count", s_count, 0);
    check("zero_cum", s_cumulative, 16);
    cycle();
`endif

    // Clear at build index 5, then a reload that must not see the old counts
    clear_tbl();
    check("clr_err", err_zero, 0);
    wr(0, 3, 0);
    wr(1, 5, 0);
    wr(2, 8, 1);
    repeat (5) cycle();
    clear_tbl();
    check("clr_ready", tbl_ready, 0);
    check("clr_total", total_count, 0);
    repeat (3) cycle();
    wr(4, 10, 0);
    wr(5, 1, 1);
    n = 0;
    wait_ready(n);
    check("rebuild_edges", n, 16);
    check("rebuild_total", total_count, 11);
    lookup(5, 1); check("cum5", s_cumulative, 10); check("cnt5", s_count, 1);
    lookup(4, 1); check("cum4", s_cumulative, 0); check("cnt4", s_count, 10);
    cycle();

    // Three stalled cycles stretch the build to 19 edges
    clear_tbl();
    wr(3, 7, 1);
    cycle();
    ena = 1'b0;
    repeat (3) cycle();
    ena = 1'b1;
    n = 4;
    wait_ready(n);
    check("ena_build_edges", n, 19);

    // Random table with overwrites, then random traffic
    clear_tbl();
    for (int i = 0; i < NS; i++) wr(i, ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 255), 0);
    for (int i = 0; i < 4; i++) wr($urandom_range(0, NS - 1), $urandom_range(0, 255), 0);
    wr(1, 200, 1);
    n = 0;
    wait_ready(n);
    check("rand_build_edges", n, 16);
    for (int i = 0; i < 400; i++) begin
      ena     = ($urandom_range(0, 9) != 0);
      sym_vld = ($urandom_range(0, 9) < 7);
      sym_in  = SW'($urandom_range(0, NS - 1));
      out_rdy = ($urandom_range(0, 9) < 6);
      cycle();
    end
    idle();
    cycle();

    // Reset while an output is pending
    lookup(1, 1);
    check("pre_rst_vld", out_vld, 1);
    out_rdy = 1'b0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    check("mrst_total", total_count, 0);
    check("mrst_s_count", s_count, 0);
    check("mrst_s_cum", s_cumulative, 0);
    check("mrst_out_vld", out_vld, 0);
    check("mrst_tbl_ready", tbl_ready, 0);
    check("mrst_err_zero", err_zero, 0);
    #1 check("mrst_sym_rdy", sym_rdy, 0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
